// File: rtl/ppc_pkg.sv
// rtl/ppc_pkg.sv - shared mode and direction constants for the ping-pong counter
package ppc_pkg;
    localparam logic MODE_BOUNCE = 1'b0;
    localparam logic MODE_WRAP   = 1'b1;
    localparam logic DIR_UP      = 1'b1;
    localparam logic DIR_DOWN    = 1'b0;
endpackage

// File: rtl/ppc_step_unit.sv
// rtl/ppc_step_unit.sv - combinational next-value and wrap-flag computation
module ppc_step_unit
    import ppc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] min,
    input  logic [WIDTH-1:0] max,
    input  logic             dir,
    input  logic             mode,
    output logic [WIDTH-1:0] next,
    output logic             wrapped
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           over;
    logic           under;

    always_comb begin
        // One extra bit keeps out+step from aliasing back into range
        sum     = {1'b0, cur} + {1'b0, step};
        diff    = {1'b0, cur} - {1'b0, step};
        over    = sum > {1'b0, max};
        under   = (cur < step) || (diff < {1'b0, min});
        next    = cur;
        wrapped = 1'b0;
        if (dir == DIR_UP) begin
            if (!over) begin
                next = sum[WIDTH-1:0];
            end else if (mode == MODE_WRAP) begin
                next    = min;
                wrapped = 1'b1;
            end else begin
                next = max;
            end
        end else begin
            if (!under) begin
                next = diff[WIDTH-1:0];
            end else if (mode == MODE_WRAP) begin
                next    = max;
                wrapped = 1'b1;
            end else begin
                next = min;
            end
        end
    end
endmodule

// File: rtl/multi_mode_ping_pong_counter.sv
// rtl/multi_mode_ping_pong_counter.sv - bounded up/down counter with bounce and wrap modes
module multi_mode_ping_pong_counter
    import ppc_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter bit DIR_RST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             flip,
    input  logic             mode,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] min,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             direction,
    output logic [WIDTH-1:0] out,
    output logic             turn,
    output logic             wrap
);
    logic             advance;
    logic             dir_next;
    logic [WIDTH-1:0] next_val;
    logic             step_wrap;

    always_comb begin
        advance = enable && (max > min) && (out >= min) && (out <= max);
        // Flip wins over the bounds; wrap mode never turns around at a bound
        if (flip) begin
            dir_next = ~direction;
        end else if (mode == MODE_BOUNCE && out == min) begin
            dir_next = DIR_UP;
        end else if (mode == MODE_BOUNCE && out == max) begin
            dir_next = DIR_DOWN;
        end else begin
            dir_next = direction;
        end
    end

    ppc_step_unit #(.WIDTH(WIDTH)) u_step (
        .cur     (out),
        .step    (step),
        .min     (min),
        .max     (max),
        .dir     (dir_next),
        .mode    (mode),
        .next    (next_val),
        .wrapped (step_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= min;
            direction <= DIR_RST;
            turn      <= 1'b0;
            wrap      <= 1'b0;
        end else if (load) begin
            out  <= load_val;
            turn <= 1'b0;
            wrap <= 1'b0;
        end else if (advance) begin
            out       <= next_val;
            direction <= dir_next;
            turn      <= (dir_next != direction);
            wrap      <= step_wrap;
        end else begin
            turn <= 1'b0;
            wrap <= 1'b0;
        end
    end
endmodule

// File: tb/tb_multi_mode_ping_pong_counter.sv
// tb/tb_multi_mode_ping_pong_counter.sv - directed and randomized checks against a reference model
module tb_multi_mode_ping_pong_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       flip = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] step = 4'd1;
    logic [3:0] max = 4'd5;
    logic [3:0] min = 4'd2;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       direction;
    logic [3:0] out;
    logic       turn;
    logic       wrap;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] m_out;
    logic       m_dir;
    logic       m_turn;
    logic       m_wrap;

    multi_mode_ping_pong_counter #(.WIDTH(4), .DIR_RST(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .flip      (flip),
        .mode      (mode),
        .step      (step),
        .max       (max),
        .min       (min),
        .load      (load),
        .load_val  (load_val),
        .direction (direction),
        .out       (out),
        .turn      (turn),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the counting rules
    task automatic clk_edge();
        int o, s, lo, hi, nv;
        logic nd, w;
        o = m_out; s = step; lo = min; hi = max;
        if (rst) begin
            m_out = min; m_dir = 1'b1; m_turn = 1'b0; m_wrap = 1'b0;
        end else if (load) begin
            m_out = load_val; m_turn = 1'b0; m_wrap = 1'b0;
        end else if (enable && hi > lo && o >= lo && o <= hi) begin
            if (flip) nd = !m_dir;
            else if (mode == 1'b0 && o == lo) nd = 1'b1;
            else if (mode == 1'b0 && o == hi) nd = 1'b0;
            else nd = m_dir;
            nv = nd ? o + s : o - s;
            w = 1'b0;
            if (nv > hi || nv < lo) begin
                if (mode == 1'b0) nv = (nv > hi) ? hi : lo;
                else begin nv = nd ? lo : hi; w = 1'b1; end
            end
            m_turn = (nd != m_dir);
            m_dir = nd;
            m_out = 4'(nv);
            m_wrap = w;
        end else begin
            m_turn = 1'b0; m_wrap = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; load_val = 4'd9; enable = 1'b1;
        min = 4'd2; max = 4'd5; step = 4'd1; mode = 1'b0; flip = 1'b0;
        clk_edge();
        n_checks++;
        if (out !== 4'd2 || direction !== 1'b1 || turn !== 1'b0 || wrap !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: out=%0d dir=%0b turn=%0b wrap=%0b required out=2 dir=1 turn=0 wrap=0",
                     out, direction, turn, wrap);
        end
        rst = 1'b0; load = 1'b0; enable = 1'b0;
    endtask

    task automatic test_bounce();
        logic [3:0] exp_out[7] = '{4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2, 4'd3};
        logic       exp_turn[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            clk_edge();
            n_checks++;
            if (out !== exp_out[i] || turn !== exp_turn[i]) begin
                n_errors++;
                $display("FAIL bounce[%0d]: out=%0d turn=%0b required out=%0d turn=%0b",
                         i, out, turn, exp_out[i], exp_turn[i]);
            end
        end
    endtask

    task automatic test_bounce_clamp();
        logic [3:0] exp_out[7] = '{4'd4, 4'd8, 4'd9, 4'd5, 4'd1, 4'd0, 4'd4};
        rst = 1'b1; min = 4'd0; max = 4'd9; step = 4'd4; enable = 1'b1;
        clk_edge();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            clk_edge();
            n_checks++;
            if (out !== exp_out[i]) begin
                n_errors++;
                $display("FAIL clamp[%0d]: out=%0d required %0d", i, out, exp_out[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_out[3] = '{4'd8, 4'd3, 4'd8};
        logic       exp_wrap[3] = '{1'b0, 1'b1, 1'b0};
        rst = 1'b1; min = 4'd3; max = 4'd12; step = 4'd5; mode = 1'b1; enable = 1'b1;
        clk_edge();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk_edge();
            n_checks++;
            if (out !== exp_out[i] || wrap !== exp_wrap[i] || direction !== 1'b1) begin
                n_errors++;
                $display("FAIL wrap[%0d]: out=%0d wrap=%0b dir=%0b required out=%0d wrap=%0b dir=1",
                         i, out, wrap, direction, exp_out[i], exp_wrap[i]);
            end
        end
        flip = 1'b1;
        clk_edge();
        flip = 1'b0;
        n_checks++;
        if (out !== 4'd3 || direction !== 1'b0 || turn !== 1'b1 || wrap !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_flip: out=%0d dir=%0b turn=%0b wrap=%0b required out=3 dir=0 turn=1 wrap=0",
                     out, direction, turn, wrap);
        end
    endtask

    task automatic test_load_hold();
        mode = 1'b0; min = 4'd2; max = 4'd10; load = 1'b1; load_val = 4'd14; enable = 1'b1;
        clk_edge();
        load = 1'b0;
        n_checks++;
        if (out !== 4'd14) begin
            n_errors++;
            $display("FAIL load: out=%0d required 14", out);
        end
        clk_edge();
        n_checks++;
        if (out !== 4'd14 || turn !== 1'b0) begin
            n_errors++;
            $display("FAIL out_of_range_hold: out=%0d turn=%0b required out=14 turn=0", out, turn);
        end
        min = 4'd7; max = 4'd7; load = 1'b1; load_val = 4'd7;
        clk_edge();
        load = 1'b0;
        clk_edge();
        n_checks++;
        if (out !== 4'd7) begin
            n_errors++;
            $display("FAIL min_eq_max_hold: out=%0d required 7", out);
        end
        min = 4'd2; max = 4'd10; enable = 1'b0;
        clk_edge();
        n_checks++;
        if (out !== 4'd7 || turn !== 1'b0 || wrap !== 1'b0) begin
            n_errors++;
            $display("FAIL disabled_hold: out=%0d turn=%0b wrap=%0b required out=7 turn=0 wrap=0",
                     out, turn, wrap);
        end
    endtask

    task automatic test_overflow();
        rst = 1'b1; mode = 1'b1; min = 4'd0; max = 4'd15; step = 4'd15; enable = 1'b0;
        clk_edge();
        rst = 1'b0; load = 1'b1; load_val = 4'd15;
        clk_edge();
        load = 1'b0; enable = 1'b1;
        clk_edge();
        n_checks++;
        if (out !== 4'd0 || wrap !== 1'b1 || direction !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow: out=%0d wrap=%0b dir=%0b required out=0 wrap=1 dir=1",
                     out, wrap, direction);
        end
    endtask

    task automatic test_reset_priority();
        mode = 1'b0; min = 4'd4; max = 4'd9; step = 4'd2; enable = 1'b1; flip = 1'b1;
        load = 1'b1; load_val = 4'd6;
        clk_edge();
        load = 1'b0;
        clk_edge();
        flip = 1'b0;
        rst = 1'b1; load = 1'b1; load_val = 4'd5;
        clk_edge();
        rst = 1'b0; load = 1'b0;
        n_checks++;
        if (out !== 4'd4 || direction !== 1'b1 || turn !== 1'b0 || wrap !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_priority: out=%0d dir=%0b turn=%0b wrap=%0b required out=4 dir=1 turn=0 wrap=0",
                     out, direction, turn, wrap);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 49) == 0);
            load     = ($urandom_range(0, 7) == 0);
            load_val = 4'($urandom_range(0, 15));
            enable   = ($urandom_range(0, 7) != 0);
            flip     = ($urandom_range(0, 5) == 0);
            mode     = 1'($urandom_range(0, 1));
            step     = 4'($urandom_range(0, 15));
            min      = 4'($urandom_range(0, 7));
            max      = 4'($urandom_range(0, 15));
            clk_edge();
            n_checks++;
            if (out !== m_out || direction !== m_dir || turn !== m_turn || wrap !== m_wrap) begin
                n_errors++;
                $display("FAIL random[%0d]: out=%0d dir=%0b turn=%0b wrap=%0b required out=%0d dir=%0b turn=%0b wrap=%0b",
                         i, out, direction, turn, wrap, m_out, m_dir, m_turn, m_wrap);
            end
        end
    endtask

    initial begin
        m_out = 4'd0; m_dir = 1'b1; m_turn = 1'b0; m_wrap = 1'b0;
        test_reset();
        test_bounce();
        test_bounce_clamp();
        test_wrap();
        test_load_hold();
        test_overflow();
        test_reset_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
